// File: rtl/pe_mac_pkg.sv
// Shared definitions for the pe_mac dot-product element: state encoding and
// default datapath widths used by the block, its datapath and its memory model.
package pe_mac_pkg;

  localparam int WORD_WIDTH_DEF = 16;
  localparam int ADDR_WIDTH_DEF = 4;
  localparam int ACC_WIDTH_DEF  = 2 * WORD_WIDTH_DEF + ADDR_WIDTH_DEF;

  typedef enum logic [1:0] {
    IDLE  = 2'b00,
    ISSUE = 2'b01,
    ACCUM = 2'b10,
    DONE  = 2'b11
  } state_e;

endpackage

// File: rtl/pe_mac_acc.sv
// Signed multiply-accumulate datapath for pe_mac: a registered accumulator
// with synchronous clear, plus the combinational running sum.
module pe_mac_acc
  import pe_mac_pkg::*;
#(
  parameter int WORD_WIDTH = WORD_WIDTH_DEF,
  parameter int ACC_WIDTH  = ACC_WIDTH_DEF
) (
  input  logic                         clk_i,
  input  logic                         rst_i,
  input  logic                         clr_i,
  input  logic                         en_i,
  input  logic signed [WORD_WIDTH-1:0] act_i,
  input  logic signed [WORD_WIDTH-1:0] wt_i,
  output logic signed [ACC_WIDTH-1:0]  acc_o,
  output logic signed [ACC_WIDTH-1:0]  sum_o
);

  logic signed [2*WORD_WIDTH-1:0] prod_s;
  logic signed [ACC_WIDTH-1:0]    prod_ext_s;
  logic signed [ACC_WIDTH-1:0]    sum_s;
  logic signed [ACC_WIDTH-1:0]    acc_d;
  logic signed [ACC_WIDTH-1:0]    acc_q;

  // Product, sign extension and next accumulator value.
  always_comb begin
    prod_s     = act_i * wt_i;
    prod_ext_s = {{(ACC_WIDTH-2*WORD_WIDTH){prod_s[2*WORD_WIDTH-1]}}, prod_s};
    sum_s      = acc_q + prod_ext_s;
    if (clr_i) begin
      acc_d = {ACC_WIDTH{1'b0}};
    end else if (en_i) begin
      acc_d = sum_s;
    end else begin
      acc_d = acc_q;
    end
  end

  // Accumulator register.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      acc_q <= {ACC_WIDTH{1'b0}};
    end else begin
      acc_q <= acc_d;
    end
  end

  assign acc_o = acc_q;
  assign sum_o = sum_s;

endmodule

// File: rtl/pe_mac.sv
// Dot-product processing element: walks a window of weight memory, multiplies
// each weight by a streamed activation and presents the accumulated result.
module pe_mac
  import pe_mac_pkg::*;
#(
  parameter int WORD_WIDTH = WORD_WIDTH_DEF,
  parameter int ADDR_WIDTH = ADDR_WIDTH_DEF,
  parameter int ACC_WIDTH  = 2 * WORD_WIDTH + ADDR_WIDTH
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic [ADDR_WIDTH-1:0] base_addr,
  input  logic [ADDR_WIDTH:0]   len,
  input  logic [WORD_WIDTH-1:0] act_in,
  input  logic                  act_valid,
  output logic                  act_ready,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic                  mem_en,
  input  logic [WORD_WIDTH-1:0] mem_data,
  output logic [ACC_WIDTH-1:0]  result,
  output logic                  res_valid,
  input  logic                  res_ready,
  output logic                  busy
);

  localparam logic [ADDR_WIDTH:0] RAM_DEPTH_L = {1'b1, {ADDR_WIDTH{1'b0}}};
  localparam logic [ADDR_WIDTH:0] ONE_L       = {{ADDR_WIDTH{1'b0}}, 1'b1};
  localparam logic [ADDR_WIDTH:0] ZERO_L      = {(ADDR_WIDTH+1){1'b0}};

  state_e                state_q;
  logic [ADDR_WIDTH-1:0] base_q;
  logic [ADDR_WIDTH-1:0] mem_addr_q;
  logic [ADDR_WIDTH:0]   len_q;
  logic [ADDR_WIDTH:0]   k_q;
  logic                  act_ready_q;
  logic                  res_valid_q;
  logic                  busy_q;
  logic                  mem_en_q;
  logic [ACC_WIDTH-1:0]  result_q;

  logic [ADDR_WIDTH:0]   len_clamp_d;
  logic [ADDR_WIDTH:0]   k_d;
  logic [ADDR_WIDTH-1:0] addr_d;
  logic                  last_term_d;
  logic                  acc_clr_d;
  logic                  acc_en_d;
  logic [ACC_WIDTH-1:0]  acc_s;
  logic [ACC_WIDTH-1:0]  acc_sum_s;

  // Length clamp, next term index/address and datapath controls.
  always_comb begin
    if (len > RAM_DEPTH_L) begin
      len_clamp_d = RAM_DEPTH_L;
    end else begin
      len_clamp_d = len;
    end
    k_d         = k_q + ONE_L;
    addr_d      = base_q + k_d[ADDR_WIDTH-1:0];
    last_term_d = (k_d == len_q);
    acc_clr_d   = (state_q == IDLE) && start;
    acc_en_d    = (state_q == ACCUM) && act_valid;
  end

  pe_mac_acc #(
    .WORD_WIDTH(WORD_WIDTH),
    .ACC_WIDTH (ACC_WIDTH)
  ) u_acc (
    .clk_i(clk),
    .rst_i(rst),
    .clr_i(acc_clr_d),
    .en_i (acc_en_d),
    .act_i(act_in),
    .wt_i (mem_data),
    .acc_o(acc_s),
    .sum_o(acc_sum_s)
  );

  // Control FSM with registered outputs; mem_addr only moves when entering ISSUE.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      base_q      <= {ADDR_WIDTH{1'b0}};
      mem_addr_q  <= {ADDR_WIDTH{1'b0}};
      len_q       <= ZERO_L;
      k_q         <= ZERO_L;
      act_ready_q <= 1'b0;
      res_valid_q <= 1'b0;
      busy_q      <= 1'b0;
      result_q    <= {ACC_WIDTH{1'b0}};
    end else begin
      case (state_q)
        IDLE: begin
          if (start) begin
            base_q <= base_addr;
            len_q  <= len_clamp_d;
            k_q    <= ZERO_L;
            busy_q <= 1'b1;
            if (len == ZERO_L) begin
              state_q     <= DONE;
              res_valid_q <= 1'b1;
              result_q    <= {ACC_WIDTH{1'b0}};
            end else begin
              state_q    <= ISSUE;
              mem_addr_q <= base_addr;
            end
          end else begin
            busy_q <= 1'b0;
          end
        end
        ISSUE: begin
          state_q     <= ACCUM;
          act_ready_q <= 1'b1;
        end
        ACCUM: begin
          if (act_valid) begin
            act_ready_q <= 1'b0;
            k_q         <= k_d;
            if (last_term_d) begin
              state_q     <= DONE;
              res_valid_q <= 1'b1;
              result_q    <= acc_sum_s;
            end else begin
              state_q    <= ISSUE;
              mem_addr_q <= addr_d;
            end
          end else begin
            act_ready_q <= 1'b1;
          end
        end
        DONE: begin
          result_q <= acc_s;
          if (res_ready) begin
            state_q     <= IDLE;
            res_valid_q <= 1'b0;
            busy_q      <= 1'b0;
          end else begin
            res_valid_q <= 1'b1;
          end
        end
        default: begin
          state_q     <= IDLE;
          act_ready_q <= 1'b0;
          res_valid_q <= 1'b0;
          busy_q      <= 1'b0;
        end
      endcase
    end
  end

  // Memory enable launched on the falling edge so the gated clock gets one clean edge per term.
  always_ff @(negedge clk or posedge rst) begin
    if (rst) begin
      mem_en_q <= 1'b0;
    end else begin
      mem_en_q <= (state_q == ISSUE);
    end
  end

  assign act_ready = act_ready_q;
  assign mem_addr  = mem_addr_q;
  assign mem_en    = mem_en_q;
  assign result    = result_q;
  assign res_valid = res_valid_q;
  assign busy      = busy_q;

endmodule

// File: tb/tb_pe_mac.sv
// Scoreboard bench for pe_mac with a gated-clock weight memory (mem[i] = i+1)
// and directed dot-product vectors.
module tb_pe_mac;
  import pe_mac_pkg::*;

  localparam int WW   = WORD_WIDTH_DEF;
  localparam int AW   = ADDR_WIDTH_DEF;
  localparam int ACCW = ACC_WIDTH_DEF;

  typedef struct {
    logic [ACCW-1:0] res;
    int              lat;
    int              st;
  } exp_t;

  logic            clk = 1'b0;
  logic            rst = 1'b0;
  logic            start = 1'b0;
  logic [AW-1:0]   base_addr = '0;
  logic [AW:0]     len = '0;
  logic [WW-1:0]   act_in = '0;
  logic            act_valid = 1'b1;
  logic            res_ready = 1'b1;
  logic [WW-1:0]   mem_data = '0;
  logic            act_ready;
  logic [AW-1:0]   mem_addr;
  logic            mem_en;
  logic [ACCW-1:0] result;
  logic            res_valid;
  logic            busy;
  logic            gclk;

  logic [WW-1:0]   mem [16];
  exp_t            exp_q[$];
  logic [AW-1:0]   addr_q[$];
  int              checks = 0;
  int              failures = 0;
  int              cyc = 0;
  logic            seen_rise = 1'b0;
  logic            prev_valid = 1'b0;
  logic            prev_ready = 1'b0;

  pe_mac dut (
    .clk(clk), .rst(rst), .start(start), .base_addr(base_addr), .len(len),
    .act_in(act_in), .act_valid(act_valid), .act_ready(act_ready),
    .mem_addr(mem_addr), .mem_en(mem_en), .mem_data(mem_data),
    .result(result), .res_valid(res_valid), .res_ready(res_ready), .busy(busy)
  );

  always #5 clk = ~clk;

  assign gclk = clk & mem_en;

  always @(posedge gclk) mem_data <= mem[mem_addr];

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s: actual=%0h required=%0h", name, act, req);
    end
  endtask

  // Each gated memory edge must address the next expected term.
  initial forever begin
    logic [AW-1:0] ea;
    @(posedge gclk);
    #1;
    if (addr_q.size() == 0) begin
      checks++;
      failures++;
      $display("FAIL extra_mem_en_pulse: actual addr=%0h required=no pulse", mem_addr);
    end else begin
      ea = addr_q.pop_front();
      check("mem_addr", 64'(mem_addr), 64'(ea));
    end
  end

  // Result monitor: latency at the rising res_valid, value every valid cycle, hold until accepted.
  initial forever begin
    @(negedge clk);
    #2;
    if (prev_valid && !prev_ready) check("res_valid_held", 64'(res_valid), 64'(1));
    if (res_valid) begin
      if (exp_q.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL unexpected_result: actual=%0h required=no result", result);
      end else begin
        if (!seen_rise) begin
          check("latency", 64'(cyc - exp_q[0].st), 64'(exp_q[0].lat));
          seen_rise = 1'b1;
        end
        check("result", 64'(result), 64'(exp_q[0].res));
        if (res_ready) begin
          check("mem_en_pulses_left", 64'(addr_q.size()), 64'(0));
          void'(exp_q.pop_front());
          seen_rise = 1'b0;
        end
      end
    end
    prev_valid = res_valid;
    prev_ready = res_ready;
  end

  task automatic start_op(input logic [AW-1:0] b, input logic [AW:0] l, input logic [WW-1:0] a,
                          input logic [ACCW-1:0] er, input int lat);
    exp_t e;
    int   n;
    @(negedge clk);
    base_addr = b;
    len       = l;
    act_in    = a;
    start     = 1'b1;
    n = (int'(l) > 16) ? 16 : int'(l);
    for (int k = 0; k < n; k++) addr_q.push_back(AW'(int'(b) + k));
    e.res = er;
    e.lat = lat;
    e.st  = cyc;
    exp_q.push_back(e);
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic wait_idle(input string name);
    int n = 0;
    while ((busy || res_valid) && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (n >= 200) begin
      checks++;
      failures++;
      $display("FAIL %s_timeout: actual=busy required=idle within 200 cycles", name);
    end
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_busy"}, 64'(busy), 64'(0));
    check({tag, "_res_valid"}, 64'(res_valid), 64'(0));
    check({tag, "_act_ready"}, 64'(act_ready), 64'(0));
    check({tag, "_mem_en"}, 64'(mem_en), 64'(0));
    check({tag, "_mem_addr"}, 64'(mem_addr), 64'(0));
    check({tag, "_result"}, 64'(result), 64'(0));
  endtask

  initial begin
    #50000;
    $display("FAIL global_timeout: actual=running required=finished");
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures + 1);
    $fatal(1, "timeout");
  end

  initial begin
    int n;
    for (int i = 0; i < 16; i++) mem[i] = WW'(i + 1);
    #1 rst = 1'b1;
    repeat (2) @(negedge clk);
    check_all_zero("reset");
    rst = 1'b0;

    // Basic: base 0, len 4, act 2 -> 2*(1+2+3+4); a start in ACCUM must be ignored.
    start_op(4'd0, 5'd4, 16'd2, 36'd20, 9);
    @(negedge clk);
    start = 1'b1; base_addr = 4'd5; len = 5'd1;
    @(negedge clk);
    start = 1'b0;
    wait_idle("basic");

    // Wrap-around: addresses 14, 15, 0, 1 -> 15+16+1+2.
    start_op(4'd14, 5'd4, 16'd1, 36'd34, 9);
    wait_idle("wrap");

    // Zero length: result 0 one cycle after start, no memory pulse.
    start_op(4'd0, 5'd0, 16'd1, 36'd0, 1);
    wait_idle("len0");

    // Over-long length clamps to 16 terms: 1+..+16.
    start_op(4'd0, 5'd20, 16'd1, 36'd136, 33);
    wait_idle("clamp");

    // Activation stall of 3 cycles in ACCUM of term 1.
    start_op(4'd0, 5'd4, 16'd2, 36'd20, 12);
    repeat (3) @(negedge clk);
    act_valid = 1'b0;
    repeat (3) begin
      @(posedge clk);
      #1;
      check("stall_mem_en", 64'(mem_en), 64'(0));
      check("stall_mem_data", 64'(mem_data), 64'(2));
      check("stall_act_ready", 64'(act_ready), 64'(1));
    end
    @(negedge clk);
    act_valid = 1'b1;
    wait_idle("stall");

    // Consumer back-pressure for 5 cycles; a start coinciding with DONE->IDLE is ignored.
    res_ready = 1'b0;
    start_op(4'd0, 5'd2, 16'd1, 36'd3, 5);
    n = 0;
    while (!res_valid && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (n >= 50) begin
      checks++;
      failures++;
      $display("FAIL hold_wait_timeout: actual=no res_valid required=res_valid");
    end
    repeat (5) @(negedge clk);
    res_ready = 1'b1;
    start = 1'b1; base_addr = 4'd0; len = 5'd1;
    @(negedge clk);
    start = 1'b0;
    check("start_at_done_ignored", 64'(busy), 64'(0));
    wait_idle("hold");

    // Signed corner cases.
    mem[0] = 16'h8000;
    start_op(4'd0, 5'd1, 16'hFFFD, 36'd98304, 3);
    wait_idle("signed_neg_neg");
    mem[0] = 16'h7FFF;
    start_op(4'd0, 5'd1, 16'hFFFF, 36'hF_FFFF_8001, 3);
    wait_idle("signed_pos_neg");
    mem[0] = 16'h0001;

    // Reset during ACCUM of term 2 abandons the operation; the next one runs normally.
    start_op(4'd0, 5'd4, 16'd2, 36'd20, 9);
    repeat (5) @(negedge clk);
    rst = 1'b1;
    #1;
    check_all_zero("midreset");
    exp_q.delete();
    addr_q.delete();
    @(negedge clk);
    rst = 1'b0;
    start_op(4'd0, 5'd4, 16'd2, 36'd20, 9);
    wait_idle("after_reset");

    repeat (2) @(negedge clk);
    check("scoreboard_empty", 64'(exp_q.size()), 64'(0));
    check("addr_queue_empty", 64'(addr_q.size()), 64'(0));
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
